// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control.
package pipe_ctrl_pkg;

  // Controller state; the encoding is visible on state_out.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  // Default register-file index width.
  localparam int REG_ADDR_W = 5;

  // Architectural zero register; a load targeting it creates no hazard.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Control fields the ID/EX register takes on when it loads a bubble.
  localparam logic [7:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc; stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch squashing,
// memory-busy freezes and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int EXTRA_FLUSH = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  pipe_freeze,
  output logic [1:0]            state_out,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(EXTRA_FLUSH);

  state_t     state, state_nxt, ret, ret_nxt, eff_state;
  logic [2:0] fcnt, fcnt_nxt;
  logic       lu;
  logic       branch_accept;

  // Load-use hazard: EX holds a load whose non-zero destination ID reads.
  assign lu = idex_memread && (idex_rd != REG_ADDR_W'(0)) &&
              ((id_rs1_used && (id_rs1 == idex_rd)) ||
               (id_rs2_used && (id_rs2 == idex_rd)));

  // A resumed FREEZE behaves as the state it interrupted.
  assign eff_state = (state == FREEZE) ? ret : state;

  // State, flush countdown and resume-state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      ret   <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state and control outputs; priority is mem_busy, branch, then lu.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    state_nxt     = RUN;
    ret_nxt       = ret;
    fcnt_nxt      = fcnt;
    branch_accept = 1'b0;

    if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      state_nxt   = FREEZE;
      if (state != FREEZE) ret_nxt = state;
    end else if (ex_branch_taken) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      fcnt_nxt      = FLUSH_LOAD;
      state_nxt     = (EXTRA_FLUSH > 0) ? FLUSH : RUN;
      branch_accept = 1'b1;
    end else if (eff_state == FLUSH) begin
      // ID holds a squashed slot, so lu is irrelevant here.
      ifid_flush = 1'b1;
      fcnt_nxt   = fcnt - 3'd1;
      state_nxt  = (fcnt == 3'd1) ? RUN : FLUSH;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    // Reset holds the front end and bubbles both pipeline registers.
    if (!reset) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      pipe_freeze   = 1'b0;
      branch_accept = 1'b0;
    end
  end

  assign state_out = reset ? state : RUN;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_accept),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a small expectation queue.
module tb_pipeline_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int EXTRA = 1;

  typedef struct packed {
    logic [4:0]    ctl;    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
    logic [1:0]    st;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, idex_rd;
  logic          id_rs1_used, id_rs2_used, idex_memread, ex_branch_taken, mem_busy;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0]    state_out;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .EXTRA_FLUSH(EXTRA), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pipe_freeze     (pipe_freeze),
    .state_out       (state_out),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}), 32'(e.ctl));
    check({tag, "_state"}, 32'(state_out), 32'(e.st));
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
  endtask

  task automatic drive(input logic mr, input logic [AW-1:0] rd,
                       input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2,
                       input logic br, input logic busy);
    idex_memread = mr; idex_rd = rd;
    id_rs1 = r1; id_rs1_used = u1;
    id_rs2 = r2; id_rs2_used = u2;
    ex_branch_taken = br; mem_busy = busy;
  endtask

  // Drive a cycle's inputs, queue the expectation, compare mid-cycle, advance.
  task automatic step(input string tag,
                      input logic mr, input logic [AW-1:0] rd,
                      input logic [AW-1:0] r1, input logic u1,
                      input logic [AW-1:0] r2, input logic u2,
                      input logic br, input logic busy,
                      input logic [4:0] ctl, input logic [1:0] st,
                      input int stall, input int flush);
    exp_t e;
    drive(mr, rd, r1, u1, r2, u2, br, busy);
    e.ctl = ctl; e.st = st; e.stall = CW'(stall); e.flush = CW'(flush);
    sb_q.push_back(e);
    @(negedge clk);
    compare_now(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    e = '{ctl: 5'b00110, st: 2'd0, stall: '0, flush: '0};
    sb_q.push_back(e);
    compare_now("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    //          tag          mr   rd  r1 u1  r2 u2  br busy  ctl       st stall flush
    step("idle0",       1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 0, 0);
    step("lu_rs1",      1'b1, 5,  5, 1,  0, 0, 0, 0, 5'b00010, 0, 0, 0);
    step("after_lu",    1'b0, 5,  5, 1,  0, 0, 0, 0, 5'b11000, 0, 1, 0);
    step("rd_zero",     1'b1, 0,  0, 1,  0, 1, 0, 0, 5'b11000, 0, 1, 0);
    step("rs2_unused",  1'b1, 7,  3, 1,  7, 0, 0, 0, 5'b11000, 0, 1, 0);
    step("lu_rs2",      1'b1, 9,  3, 1,  9, 1, 0, 0, 5'b00010, 0, 1, 0);
    step("branch",      1'b0, 0,  0, 0,  0, 0, 1, 0, 5'b11110, 0, 2, 0);
    step("flush_slot",  1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11100, 1, 2, 1);
    step("back_run",    1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 2, 1);
    step("branch2",     1'b0, 0,  0, 0,  0, 0, 1, 0, 5'b11110, 0, 2, 1);
    step("busy1",       1'b0, 0,  0, 0,  0, 0, 1, 1, 5'b00001, 1, 2, 2);
    step("busy2",       1'b1, 5,  5, 1,  0, 0, 0, 1, 5'b00001, 2, 3, 2);
    step("busy3",       1'b0, 0,  0, 0,  0, 0, 0, 1, 5'b00001, 2, 4, 2);
    step("resume_fl",   1'b1, 5,  5, 1,  0, 0, 0, 0, 5'b11100, 2, 5, 2);
    step("run_again",   1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 5, 2);
    step("br_and_lu",   1'b1, 4,  4, 1,  0, 0, 1, 0, 5'b11110, 0, 5, 2);
    step("flush_lu",    1'b1, 4,  4, 1,  0, 0, 0, 0, 5'b11100, 1, 5, 3);
    step("run3",        1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 5, 3);

    // Push stall_cnt into saturation with back-to-back load-use stalls.
    for (int i = 0; i < 14; i++) begin
      step("lu_sat",    1'b1, 6,  0, 0,  6, 1, 0, 0, 5'b00010, 0,
           (5 + i > 15) ? 15 : 5 + i, 3);
    end
    step("sat_hold",    1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 15, 3);

    // Enter FREEZE from RUN, then reset asynchronously while frozen.
    step("frz_run1",    1'b0, 0,  0, 0,  0, 0, 0, 1, 5'b00001, 0, 15, 3);
    step("frz_run2",    1'b0, 0,  0, 0,  0, 0, 0, 1, 5'b00001, 2, 15, 3);
    reset = 1'b0;
    #1;
    e = '{ctl: 5'b00110, st: 2'd0, stall: '0, flush: '0};
    sb_q.push_back(e);
    compare_now("async_rst");
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    step("post_rst",    1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11000, 0, 0, 0);
    step("post_rst_br", 1'b0, 0,  0, 0,  0, 0, 1, 0, 5'b11110, 0, 0, 0);
    step("post_rst_fl", 1'b0, 0,  0, 0,  0, 0, 0, 0, 5'b11100, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
